// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/HI-LO stalls,
// control-flow flushes, and the multi-cycle mult/div busy tracker.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jumpD,
  input  logic       pcsrcD,
  input  logic       mfhiloD,
  input  logic       mdstartE,
  input  logic       mdopE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mdbusy,
  output logic       mddone,
  output logic [5:0] mdcount
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  md_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mdcount <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (mdstartE) begin
            state   <= BUSY;
            mdcount <= mdopE ? 6'(DIV_CYCLES - 1) : 6'(MULT_CYCLES - 1);
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          // new starts are ignored until the current op finishes
          if (mdcount == 6'd0) state <= DONE;
          else                 mdcount <= mdcount - 6'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdbusy = (state == BUSY);
  assign mddone = (state == DONE);

  logic mhit_rsE, mhit_rtE, whit_rsE, whit_rtE;
  logic lwstall, branchstall, mdstall, stall;
  logic ehit, mhit;

  assign mhit_rsE = regwriteM && (writeregM != 5'd0) && (writeregM == rsE);
  assign mhit_rtE = regwriteM && (writeregM != 5'd0) && (writeregM == rtE);
  assign whit_rsE = regwriteW && (writeregW != 5'd0) && (writeregW == rsE);
  assign whit_rtE = regwriteW && (writeregW != 5'd0) && (writeregW == rtE);

  assign lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign ehit    = regwriteE && (writeregE != 5'd0) &&
                   ((writeregE == rsD) || (writeregE == rtD));
  assign mhit    = memtoregM && (writeregM != 5'd0) &&
                   ((writeregM == rsD) || (writeregM == rtD));
  assign branchstall = branchD && (ehit || mhit);
  assign mdstall     = mfhiloD && mdbusy;
  assign stall       = lwstall || branchstall || mdstall;

  // every combinational output is held low while reset is asserted
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushE    = 1'b0;
    flushD    = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (!rst) begin
      stallF    = stall;
      stallD    = stall;
      flushE    = stall;
      flushD    = (pcsrcD || jumpD) && !stall;
      forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
      forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
      forwardAE = mhit_rsE ? 2'b10 : (whit_rsE ? 2'b01 : 2'b00);
      forwardBE = mhit_rtE ? 2'b10 : (whit_rtE ? 2'b01 : 2'b00);
    end
  end

endmodule
